regfile_2r1w: RTL and testbench
===============================

// Module: regfile_2r1w
// PURPOSE
//  ARM-core general register file: 16 x WIDTH storage, two read ports, one write port.
//  Sits between decode (reads operands, claims destinations) and writeback (commits results).
//  Scoreboard of pending writes lets decode stall on RAW hazards.
//  r15 is not stored here: its reads return pc_in, and writes to it are redirected to the fetch unit.
// PARAMETERS
//  WIDTH  32  data width of each register
//  NREGS  16  number of architectural registers; index NREGS-1 is the PC alias
//  AW     4   address width, $clog2(NREGS)
// PORTS
//  clk          in   1      clock, all state updates on posedge
//  rst          in   1      reset, asynchronous, active-high
//  rd_addr_a    in   AW     read port A register index
//  rd_data_a    out  WIDTH  read port A data (combinational)
//  pend_a       out  1      register at rd_addr_a has an outstanding claimed write
//  rd_addr_b    in   AW     read port B register index
//  rd_data_b    out  WIDTH  read port B data (combinational)
//  pend_b       out  1      register at rd_addr_b has an outstanding claimed write
//  pc_in        in   WIDTH  current architectural PC value (already +8 adjusted by fetch)
//  claim_en     in   1      decode issues an instr that will write claim_addr
//  claim_addr   in   AW     destination register being claimed
//  wr_en        in   1      writeback commit strobe
//  wr_addr      in   AW     writeback destination index
//  wr_data      in   WIDTH  writeback data
//  pc_wr_valid  out  1      registered pulse: writeback targeted r15
//  pc_wr_data   out  WIDTH  registered data of that r15 write
//  claim_err    out  1      registered pulse: claim on an already-pending register
// BEHAVIOUR
//  Reset (async, rst=1): all regs[0..NREGS-2] = 0.
//   - pending[] = 0; pc_wr_valid = 0; pc_wr_data = 0; claim_err = 0.
//   - Read outputs are combinational, so rd_data_* = 0 for r0..r14 during reset.
//  Reads (zero latency, combinational):
//   - addr == NREGS-1: data = pc_in, pend = 0.
//   - else if wr_en && wr_addr == addr: data = wr_data (write-through bypass), pend = 0.
//   - else: data = regs[addr], pend = pending[addr].
//   - Both ports are independent; identical addresses return identical data.
//  Write (posedge, wr_en=1):
//   - wr_addr < NREGS-1: regs[wr_addr] <= wr_data; pending[wr_addr] <= 0, unless overridden by claim below.
//   - wr_addr == NREGS-1: no storage update; next cycle pc_wr_valid=1 and pc_wr_data=wr_data.
//   - pc_wr_valid is 1 for exactly one cycle per r15 write; back-to-back r15 writes give back-to-back pulses.
//  Claim (posedge, claim_en=1, claim_addr < NREGS-1):
//   - If pending[claim_addr] is set and not being cleared this cycle: next cycle claim_err=1; pending stays 1.
//   - Otherwise: pending[claim_addr] <= 1.
//   - Claims to r15 are ignored: no pending bit, no error.
//  Simultaneous claim and write, same register: claim wins, so pending ends at 1.
//   - The write data is still stored; the new owner is the in-flight instr.
//   - No claim_err in this case, because the old claim retires in the same cycle.
//  Claim and write to different registers in the same cycle: both take effect.
//  Out-of-range addresses (>= NREGS when NREGS < 2^AW): reads return 0 with pend=0; writes and claims are dropped.
//  rst asserted mid-operation: immediate clear of all state.
//   - Outstanding claims are lost; pipeline flush is the owner's job.
// TESTING
//  1. After rst: read a=3, b=7 -> data 0/0, pend 0/0; read a=15 with pc_in=0x100 -> data 0x100.
//  2. wr_en, addr 5, data 0xDEADBEEF -> same-cycle rd_addr_a=5 shows 0xDEADBEEF;
//     next cycle regs[5]=0xDEADBEEF.
//  3. claim r2 -> pend_a(2)=1; claim r2 again -> claim_err pulse next cycle;
//     wr r2 0x11 -> pend 0, data 0x11 in the same cycle.
//  4. Same cycle: claim r4 and wr r4 0x22 -> next cycle regs[4]=0x22, pend=1, claim_err=0.
//  5. wr_en r15 0x8000 -> next cycle pc_wr_valid=1 and pc_wr_data=0x8000;
//     cycle after, pc_wr_valid=0; read r15 still = pc_in.
//  6. Claim r9, then assert rst asynchronously mid-cycle -> pend(9)=0, regs=0 immediately,
//     outputs stay at reset values.

Source files
------------

// File: rtl/regfile_2r1w.sv
// General register file for the ARM core: 16 x WIDTH, two combinational read
// ports, one write port, plus a per-register scoreboard of claimed writes.
// r15 is never stored: reads return pc_in, writes become a one-cycle pulse
// to the fetch unit on pc_wr_valid/pc_wr_data.
// There is no valid/ready handshake here: claim_en and wr_en are single-cycle
// strobes that are always accepted at the posedge they are sampled on, and
// pc_wr_valid/claim_err are single-cycle pulses with no backpressure.
module regfile_2r1w #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  output logic             pend_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             pend_b,
  input  logic [WIDTH-1:0] pc_in,
  input  logic             claim_en,
  input  logic [AW-1:0]    claim_addr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             pc_wr_valid,
  output logic [WIDTH-1:0] pc_wr_data,
  output logic             claim_err
);

  // Index of the PC alias; anything above it is out of range and ignored.
  localparam logic [AW-1:0] PC_ADDR = AW'(NREGS - 1);

  logic [WIDTH-1:0] regs_q [NREGS-1];
  logic [WIDTH-1:0] regs_d [NREGS-1];
  logic [NREGS-2:0] pending_q, pending_d;
  logic             pc_wr_valid_q, pc_wr_valid_d;
  logic [WIDTH-1:0] pc_wr_data_q, pc_wr_data_d;
  logic             claim_err_q, claim_err_d;

  logic wr_store;  // write lands in storage (r0..r14)
  logic wr_pc;     // write is redirected to fetch
  logic claim_ok;  // claim targets a stored register
  logic rd_in_a, rd_in_b;

  assign wr_store = wr_en && (wr_addr < PC_ADDR);
  assign wr_pc    = wr_en && (wr_addr == PC_ADDR);
  assign claim_ok = claim_en && (claim_addr < PC_ADDR);
  assign rd_in_a  = rd_addr_a < PC_ADDR;
  assign rd_in_b  = rd_addr_b < PC_ADDR;

  // Next-state: commit writes, then apply claims so a same-register claim wins.
  always_comb begin
    regs_d        = regs_q;
    pending_d     = pending_q;
    pc_wr_valid_d = wr_pc;
    pc_wr_data_d  = pc_wr_data_q;
    claim_err_d   = 1'b0;
    if (wr_pc) begin
      pc_wr_data_d = wr_data;
    end
    for (int i = 0; i < NREGS - 1; i++) begin
      if (wr_store && (wr_addr == AW'(i))) begin
        regs_d[i]    = wr_data;
        pending_d[i] = 1'b0;
      end
    end
    for (int i = 0; i < NREGS - 1; i++) begin
      if (claim_ok && (claim_addr == AW'(i))) begin
        // A claim on a register whose old owner retires this same cycle is legal.
        if (pending_q[i] && !(wr_store && (wr_addr == claim_addr))) begin
          claim_err_d = 1'b1;
        end
        pending_d[i] = 1'b1;
      end
    end
  end

  // State registers, cleared asynchronously so a flush takes effect immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS - 1; i++) begin
        regs_q[i] <= '0;
      end
      pending_q     <= '0;
      pc_wr_valid_q <= 1'b0;
      pc_wr_data_q  <= '0;
      claim_err_q   <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      pending_q     <= pending_d;
      pc_wr_valid_q <= pc_wr_valid_d;
      pc_wr_data_q  <= pc_wr_data_d;
      claim_err_q   <= claim_err_d;
    end
  end

  // Read port A: PC alias, then write-through bypass, then storage.
  always_comb begin
    rd_data_a = '0;
    pend_a    = 1'b0;
    if (rd_addr_a == PC_ADDR) begin
      rd_data_a = pc_in;
    end else if (rd_in_a) begin
      if (wr_en && !rst && (wr_addr == rd_addr_a)) begin
        rd_data_a = wr_data;
      end else begin
        rd_data_a = regs_q[rd_addr_a];
        pend_a    = pending_q[rd_addr_a];
      end
    end
  end

  // Read port B: same rules as port A, fully independent.
  always_comb begin
    rd_data_b = '0;
    pend_b    = 1'b0;
    if (rd_addr_b == PC_ADDR) begin
      rd_data_b = pc_in;
    end else if (rd_in_b) begin
      if (wr_en && !rst && (wr_addr == rd_addr_b)) begin
        rd_data_b = wr_data;
      end else begin
        rd_data_b = regs_q[rd_addr_b];
        pend_b    = pending_q[rd_addr_b];
      end
    end
  end

  assign pc_wr_valid = pc_wr_valid_q;
  assign pc_wr_data  = pc_wr_data_q;
  assign claim_err   = claim_err_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: directed vectors with literal checks, plus a
// register-file model compared against every output on each falling edge.
module tb_regfile_2r1w;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic [3:0]   rd_addr_a, rd_addr_b, claim_addr, wr_addr;
  logic [W-1:0] rd_data_a, rd_data_b, pc_in, wr_data, pc_wr_data;
  logic         pend_a, pend_b, claim_en, wr_en, pc_wr_valid, claim_err;

  int n_cmp  = 0;
  int n_fail = 0;

  regfile_2r1w #(.WIDTH(W), .NREGS(16), .AW(4)) dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .pend_a(pend_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .pend_b(pend_b),
    .pc_in(pc_in),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pc_wr_valid(pc_wr_valid), .pc_wr_data(pc_wr_data),
    .claim_err(claim_err)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [W-1:0] m_regs [15];
  logic [14:0]  m_pend;
  logic         m_pcv, m_err;
  logic [W-1:0] m_pcd;

  // Architectural state as the register-file rules describe it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) m_regs[i] = '0;
      m_pend = '0;
      m_pcv  = 1'b0;
      m_pcd  = '0;
      m_err  = 1'b0;
    end else begin
      logic retire;
      retire = wr_en && (wr_addr == claim_addr);
      m_err  = claim_en && (claim_addr != 4'd15) && m_pend[claim_addr] && !retire;
      m_pcv  = wr_en && (wr_addr == 4'd15);
      if (m_pcv) m_pcd = wr_data;
      if (wr_en && wr_addr != 4'd15) begin
        m_regs[wr_addr] = wr_data;
        m_pend[wr_addr] = 1'b0;
      end
      if (claim_en && claim_addr != 4'd15) m_pend[claim_addr] = 1'b1;
    end
  end

  function automatic logic [W-1:0] exp_data(input logic [3:0] a);
    if (a == 4'd15) return pc_in;
    if (wr_en && !rst && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_pend(input logic [3:0] a);
    if (a == 4'd15) return 1'b0;
    if (wr_en && !rst && wr_addr == a) return 1'b0;
    return m_pend[a];
  endfunction

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    check("m_rd_data_a", rd_data_a, exp_data(rd_addr_a));
    check("m_rd_data_b", rd_data_b, exp_data(rd_addr_b));
    check("m_pend_a", W'(pend_a), W'(exp_pend(rd_addr_a)));
    check("m_pend_b", W'(pend_b), W'(exp_pend(rd_addr_b)));
    check("m_pc_wr_valid", W'(pc_wr_valid), W'(m_pcv));
    check("m_pc_wr_data", pc_wr_data, m_pcd);
    check("m_claim_err", W'(claim_err), W'(m_err));
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rd_addr_a = '0; rd_addr_b = '0; pc_in = '0;
    claim_en = 1'b0; claim_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    tick();
    tick();

    // 1. reset values, PC alias
    rd_addr_a = 4'd3; rd_addr_b = 4'd7; pc_in = 32'h100;
    #1;
    check("rst_data_a", rd_data_a, 32'h0);
    check("rst_data_b", rd_data_b, 32'h0);
    check("rst_pend_a", W'(pend_a), 32'h0);
    check("rst_pend_b", W'(pend_b), 32'h0);
    check("rst_pcv", W'(pc_wr_valid), 32'h0);
    check("rst_err", W'(claim_err), 32'h0);
    rst = 1'b0;
    rd_addr_a = 4'd15;
    #1;
    check("pc_alias", rd_data_a, 32'h100);
    tick();

    // 2. write-through bypass and storage
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF; rd_addr_a = 4'd5;
    #1;
    check("bypass_r5", rd_data_a, 32'hDEADBEEF);
    tick();
    wr_en = 1'b0;
    #1;
    check("stored_r5", rd_data_a, 32'hDEADBEEF);
    check("stored_r5_pend", W'(pend_a), 32'h0);

    // 3. claim, double claim, retire
    claim_en = 1'b1; claim_addr = 4'd2; rd_addr_a = 4'd2;
    tick();
    #1;
    check("claim_r2_pend", W'(pend_a), 32'h1);
    check("claim_r2_noerr", W'(claim_err), 32'h0);
    tick();
    claim_en = 1'b0;
    #1;
    check("dbl_claim_err", W'(claim_err), 32'h1);
    check("dbl_claim_pend", W'(pend_a), 32'h1);
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h11;
    #1;
    check("retire_r2_data", rd_data_a, 32'h11);
    check("retire_r2_pend", W'(pend_a), 32'h0);
    tick();
    wr_en = 1'b0;
    #1;
    check("err_one_cycle", W'(claim_err), 32'h0);
    check("r2_after_pend", W'(pend_a), 32'h0);
    check("r2_after_data", rd_data_a, 32'h11);

    // 4. claim and write same register: claim wins, no error
    claim_en = 1'b1; claim_addr = 4'd4; wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'h22;
    rd_addr_b = 4'd4;
    tick();
    claim_en = 1'b0; wr_en = 1'b0;
    #1;
    check("cw_same_data", rd_data_b, 32'h22);
    check("cw_same_pend", W'(pend_b), 32'h1);
    check("cw_same_err", W'(claim_err), 32'h0);

    // claim and write to different registers
    claim_en = 1'b1; claim_addr = 4'd6; wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h77;
    tick();
    claim_en = 1'b0; wr_en = 1'b0; rd_addr_a = 4'd6; rd_addr_b = 4'd7;
    #1;
    check("cw_diff_pend6", W'(pend_a), 32'h1);
    check("cw_diff_data7", rd_data_b, 32'h77);
    check("cw_diff_pend7", W'(pend_b), 32'h0);

    // 5. r15 write goes to fetch
    wr_en = 1'b1; wr_addr = 4'd15; wr_data = 32'h8000;
    tick();
    wr_en = 1'b0;
    #1;
    check("pcw_valid", W'(pc_wr_valid), 32'h1);
    check("pcw_data", pc_wr_data, 32'h8000);
    tick();
    rd_addr_a = 4'd15; pc_in = 32'h200;
    #1;
    check("pcw_drop", W'(pc_wr_valid), 32'h0);
    check("pcw_read_pc", rd_data_a, 32'h200);
    check("pcw_pend_pc", W'(pend_a), 32'h0);
    // back-to-back r15 writes
    wr_en = 1'b1; wr_addr = 4'd15; wr_data = 32'h10;
    tick();
    wr_data = 32'h20;
    #1;
    check("b2b_valid1", W'(pc_wr_valid), 32'h1);
    check("b2b_data1", pc_wr_data, 32'h10);
    tick();
    wr_en = 1'b0;
    #1;
    check("b2b_valid2", W'(pc_wr_valid), 32'h1);
    check("b2b_data2", pc_wr_data, 32'h20);

    // claims on r15 are ignored
    claim_en = 1'b1; claim_addr = 4'd15;
    tick();
    tick();
    claim_en = 1'b0;
    #1;
    check("claim_r15_err", W'(claim_err), 32'h0);

    // fill all stored registers, read back on both ports
    for (int i = 0; i < 15; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 32'h01010101 * (i + 1);
      rd_addr_a = 4'(i); rd_addr_b = 4'((i + 14) % 15);
      tick();
    end
    wr_en = 1'b0;
    rd_addr_a = 4'd14; rd_addr_b = 4'd0;
    #1;
    check("fill_r14", rd_data_a, 32'h0F0F0F0F);
    check("fill_r0", rd_data_b, 32'h01010101);

    // 6. asynchronous reset mid-cycle
    claim_en = 1'b1; claim_addr = 4'd9;
    tick();
    claim_en = 1'b0; rd_addr_a = 4'd9; rd_addr_b = 4'd5;
    #1;
    check("pre_rst_pend9", W'(pend_a), 32'h1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_pend9", W'(pend_a), 32'h0);
    check("arst_r5", rd_data_b, 32'h0);
    check("arst_r9", rd_data_a, 32'h0);
    check("arst_pcd", pc_wr_data, 32'h0);
    tick();
    #1;
    check("arst_hold_r5", rd_data_b, 32'h0);
    rst = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
